bp_unit: RTL and testbench

- Parametrised branch prediction and resolution unit for the RV32I pipeline.
- Fetch side: combinational lookup of a direct-mapped BTB plus a table of saturating direction counters (PHT) yields a predicted next-PC.
- Execute side: compares the prediction carried down the pipeline against the resolved outcome, raises a flush/redirect, and trains both tables on the clock edge.
- Generalises the single-cycle misprediction check with configurable table depth, counter width, address width, tag compare, invalidation and statistics.

---
 rtl/bp_unit.sv | 158 +++++++++++++++
 tb/tb_bp_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_unit.sv
// bp_unit: branch prediction (BTB + saturating-counter PHT) and EX-stage resolution/training
//
// Optional feature macro: BP_GSHARE_EN (PHT index XORed with global history).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   fetch_pc                      PC being fetched
//   pred_taken, pred_target       fetch-side prediction (combinational)
//   pred_ghr                      history snapshot to carry down the pipe (0 without BP_GSHARE_EN)
//   ex_valid, ex_pc               EX instruction valid and its PC
//   ex_is_branch, ex_is_jump      conditional branch / JAL-JALR (jump wins if both set)
//   ex_taken, ex_target           resolved outcome and target
//   ex_pred_taken/_target, ex_ghr prediction carried from fetch
//   mispredict, redirect_pc       flush request and correct next PC (combinational)
//   stat_branches, stat_mispredicts  saturating statistics counters
module bp_unit #(
    parameter int XLEN      = 32,
    parameter int BTB_IDX_W = 6,
    parameter int CTR_W     = 2,
    parameter int STAT_W    = 32,
    parameter int GHR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   fetch_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_is_branch,
    input  logic              ex_is_jump,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    input  logic [GHR_W-1:0]  ex_ghr,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);
    localparam int N     = 1 << BTB_IDX_W;
    localparam int TAG_W = XLEN - BTB_IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};

    logic [N-1:0]         r_valid;
    logic [TAG_W-1:0]     r_tag [N];
    logic [XLEN-1:0]      r_tgt [N];
    logic [CTR_W-1:0]     r_pht [N];
    logic [STAT_W-1:0]    r_stat_br;
    logic [STAT_W-1:0]    r_stat_mis;

    logic [BTB_IDX_W-1:0] w_f_idx;
    logic [BTB_IDX_W-1:0] w_f_pidx;
    logic [BTB_IDX_W-1:0] w_e_idx;
    logic [BTB_IDX_W-1:0] w_e_pidx;
    logic [TAG_W-1:0]     w_f_tag;
    logic [TAG_W-1:0]     w_e_tag;
    logic                 w_f_hit;
    logic                 w_jump;
    logic                 w_br;
    logic                 w_ctl;
    logic                 w_wr_btb;
    logic                 w_inval;
    logic [CTR_W-1:0]     w_ctr;
    logic [CTR_W-1:0]     w_ctr_next;

    assign w_f_idx = fetch_pc[BTB_IDX_W+1:2];
    assign w_f_tag = fetch_pc[XLEN-1:BTB_IDX_W+2];
    assign w_e_idx = ex_pc[BTB_IDX_W+1:2];
    assign w_e_tag = ex_pc[XLEN-1:BTB_IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] r_ghr;
    assign w_f_pidx = w_f_idx ^ BTB_IDX_W'(r_ghr);
    assign w_e_pidx = w_e_idx ^ BTB_IDX_W'(ex_ghr);
    assign pred_ghr = r_ghr;
    // History is updated only at resolution, so it never needs repair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ghr <= '0;
        else if (ex_valid && w_br)
            r_ghr <= {r_ghr[GHR_W-2:0], ex_taken};
    end
`else
    logic w_unused_ghr;
    assign w_f_pidx     = w_f_idx;
    assign w_e_pidx     = w_e_idx;
    assign pred_ghr     = '0;
    assign w_unused_ghr = ^ex_ghr;
`endif

    assign w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign pred_taken  = w_f_hit && r_pht[w_f_pidx][CTR_W-1];
    assign pred_target = pred_taken ? r_tgt[w_f_idx] : fetch_pc + XLEN'(4);

    assign w_jump = ex_is_jump;
    assign w_br   = ex_is_branch && !ex_is_jump;
    assign w_ctl  = ex_is_branch || ex_is_jump;

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (ex_valid) begin
            if (w_jump) begin
                mispredict  = !ex_pred_taken || (ex_pred_target != ex_target);
                redirect_pc = ex_target;
            end else if (w_br) begin
                mispredict  = (ex_pred_taken != ex_taken) || (ex_taken && (ex_pred_target != ex_target));
                redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);
            end else begin
                mispredict  = ex_pred_taken;
                redirect_pc = ex_pc + XLEN'(4);
            end
        end
    end

    assign w_wr_btb   = ex_valid && (w_jump || (w_br && ex_taken));
    // A non-control instruction predicted taken hit a stale entry; drop it only if it is really ours.
    assign w_inval    = ex_valid && !w_ctl && ex_pred_taken && (r_tag[w_e_idx] == w_e_tag);
    assign w_ctr      = r_pht[w_e_pidx];
    assign w_ctr_next = w_jump   ? '1 :
                        ex_taken ? ((w_ctr == '1) ? w_ctr : w_ctr + CTR_W'(1)) :
                                   ((w_ctr == '0) ? w_ctr : w_ctr - CTR_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= '0;
            r_stat_br  <= '0;
            r_stat_mis <= '0;
            for (int i = 0; i < N; i++)
                r_pht[i] <= CTR_INIT;
        end else if (ex_valid) begin
            if (w_wr_btb)
                r_valid[w_e_idx] <= 1'b1;
            else if (w_inval)
                r_valid[w_e_idx] <= 1'b0;
            if (w_ctl)
                r_pht[w_e_pidx] <= w_ctr_next;
            if (w_ctl && (r_stat_br != '1))
                r_stat_br <= r_stat_br + STAT_W'(1);
            if (mispredict && (r_stat_mis != '1))
                r_stat_mis <= r_stat_mis + STAT_W'(1);
        end
    end

    // Tag/target need no reset: an entry is only visible once its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_wr_btb) begin
            r_tag[w_e_idx] <= w_e_tag;
            r_tgt[w_e_idx] <= ex_target;
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mis;
endmodule

// File: tb/tb_bp_unit.sv
// tb_bp_unit: directed table, reset sequences and randomized model-checked run for bp_unit
module tb_bp_unit;
    localparam int SW = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   fetch_pc = '0;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic [5:0]    pred_ghr;
    logic          ex_valid = 1'b0;
    logic [31:0]   ex_pc = '0;
    logic          ex_is_branch = 1'b0;
    logic          ex_is_jump = 1'b0;
    logic          ex_taken = 1'b0;
    logic [31:0]   ex_target = '0;
    logic          ex_pred_taken = 1'b0;
    logic [31:0]   ex_pred_target = '0;
    logic [5:0]    ex_ghr = '0;
    logic          mispredict;
    logic [31:0]   redirect_pc;
    logic [SW-1:0] stat_branches;
    logic [SW-1:0] stat_mispredicts;

    int checks = 0;
    int errors = 0;

    bp_unit #(.XLEN(32), .BTB_IDX_W(6), .CTR_W(2), .STAT_W(SW), .GHR_W(6)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_ghr(pred_ghr),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .ex_ghr(ex_ghr),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f_pc;
        logic        v;
        logic [31:0] pc;
        logic        br;
        logic        jp;
        logic        tk;
        logic [31:0] tgt;
        logic        ppt;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mis;
        logic [31:0] e_red;
    } vec_t;

    vec_t tbl[17];

    // Reference model: plain arrays indexed by pc word index, default (non-gshare) build.
    bit          m_v   [64];
    int unsigned m_tag [64];
    logic [31:0] m_tgt [64];
    int          m_ctr [64];
    int          m_nbr;
    int          m_nmis;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 64; i++) begin
            m_v[i] = 0;
            m_ctr[i] = 1;
        end
        m_nbr = 0;
        m_nmis = 0;
    endfunction

    function automatic logic [32:0] m_pred(input logic [31:0] pc);
        int idx = int'((pc >> 2) % 64);
        bit hit = m_v[idx] && (m_tag[idx] == (pc >> 8));
        bit t = hit && (m_ctr[idx] >= 2);
        return {t, t ? m_tgt[idx] : pc + 32'd4};
    endfunction

    function automatic logic [32:0] m_res(input logic v, input logic [31:0] pc, input logic br, input logic jp,
                                          input logic tk, input logic [31:0] tgt, input logic ppt,
                                          input logic [31:0] ptgt);
        if (!v) return 33'd0;
        if (jp) return {!ppt || ptgt != tgt, tgt};
        if (br) return {(ppt != tk) || (tk && ptgt != tgt), tk ? tgt : pc + 32'd4};
        return {ppt, pc + 32'd4};
    endfunction

    function automatic void m_train(input logic [31:0] pc, input logic br, input logic jp, input logic tk,
                                    input logic [31:0] tgt, input logic ppt, input logic mis);
        int idx = int'((pc >> 2) % 64);
        if (jp) begin
            m_v[idx] = 1; m_tag[idx] = pc >> 8; m_tgt[idx] = tgt; m_ctr[idx] = 3;
        end else if (br) begin
            m_ctr[idx] = tk ? (m_ctr[idx] < 3 ? m_ctr[idx] + 1 : 3) : (m_ctr[idx] > 0 ? m_ctr[idx] - 1 : 0);
            if (tk) begin
                m_v[idx] = 1; m_tag[idx] = pc >> 8; m_tgt[idx] = tgt;
            end
        end else if (ppt && m_tag[idx] == (pc >> 8))
            m_v[idx] = 0;
        if ((br || jp) && m_nbr < SMAX) m_nbr++;
        if (mis && m_nmis < SMAX) m_nmis++;
    endfunction

    function automatic vec_t mk(input logic [31:0] f_pc, input logic v, input logic [31:0] pc,
                                input logic br, input logic jp, input logic tk, input logic [31:0] tgt,
                                input logic ppt, input logic [31:0] ptgt, input logic e_pt,
                                input logic [31:0] e_ptgt, input logic e_mis, input logic [31:0] e_red);
        vec_t r;
        r.f_pc = f_pc; r.v = v; r.pc = pc; r.br = br; r.jp = jp; r.tk = tk; r.tgt = tgt;
        r.ppt = ppt; r.ptgt = ptgt; r.e_pt = e_pt; r.e_ptgt = e_ptgt; r.e_mis = e_mis; r.e_red = e_red;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic br, input logic jp,
                         input logic tk, input logic [31:0] tgt, input logic ppt, input logic [31:0] ptgt);
        ex_valid = v; ex_pc = pc; ex_is_branch = br; ex_is_jump = jp;
        ex_taken = tk; ex_target = tgt; ex_pred_taken = ppt; ex_pred_target = ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [32:0] p;
        logic [32:0] r;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        v, br, jp, tk, ppt;
        logic [31:0] ptgt;
        int          k;

        //            f_pc    v  pc      br jp tk tgt     ppt ptgt    e_pt e_ptgt  mis red
        tbl[0]  = mk(32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80);
        tbl[1]  = mk(32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h0);
        tbl[2]  = mk(32'h100, 1, 32'h100, 1, 0, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104);
        tbl[3]  = mk(32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80);
        tbl[4]  = mk(32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80);
        tbl[5]  = mk(32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80);
        tbl[6]  = mk(32'h100, 1, 32'h100, 1, 0, 1, 32'h80,  1, 32'h80,  1, 32'h80,  0, 32'h80);
        tbl[7]  = mk(32'h100, 1, 32'h100, 1, 0, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104);
        tbl[8]  = mk(32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h0);
        tbl[9]  = mk(32'h200, 1, 32'h200, 0, 1, 1, 32'h400, 1, 32'h3FC, 0, 32'h204, 1, 32'h400);
        tbl[10] = mk(32'h200, 1, 32'h200, 0, 1, 1, 32'h400, 1, 32'h400, 1, 32'h400, 0, 32'h400);
        tbl[11] = mk(32'h100, 1, 32'h1100,0, 0, 0, 32'h0,   1, 32'h80,  0, 32'h104, 1, 32'h1104);
        tbl[12] = mk(32'h200, 1, 32'h200, 0, 0, 0, 32'h0,   1, 32'h400, 1, 32'h400, 1, 32'h204);
        tbl[13] = mk(32'h200, 0, 32'h200, 0, 1, 1, 32'h400, 0, 32'h3FC, 0, 32'h204, 0, 32'h0);
        tbl[14] = mk(32'h200, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   0, 32'h204, 0, 32'h0);
        tbl[15] = mk(32'h200, 1, 32'h300, 1, 1, 0, 32'h500, 0, 32'h304, 0, 32'h204, 1, 32'h500);
        tbl[16] = mk(32'h300, 0, 32'h0,   0, 0, 0, 32'h0,   0, 32'h0,   1, 32'h500, 0, 32'h0);

        fetch_pc = 32'h100;
        #12 rst = 1'b0;
        #1;
        chk("reset_pred_taken", 32'(pred_taken), 32'd0);
        chk("reset_pred_target", pred_target, 32'h104);
        chk("reset_pred_ghr", 32'(pred_ghr), 32'd0);
        chk("reset_stat_br", 32'(stat_branches), 32'd0);
        chk("reset_stat_mis", 32'(stat_mispredicts), 32'd0);
        tick();

        for (int i = 0; i < 17; i++) begin
            fetch_pc = tbl[i].f_pc;
            drive(tbl[i].v, tbl[i].pc, tbl[i].br, tbl[i].jp, tbl[i].tk, tbl[i].tgt, tbl[i].ppt, tbl[i].ptgt);
            #3;
            chk($sformatf("tbl%0d_pred_taken", i), 32'(pred_taken), 32'(tbl[i].e_pt));
            chk($sformatf("tbl%0d_pred_target", i), pred_target, tbl[i].e_ptgt);
            chk($sformatf("tbl%0d_mispredict", i), 32'(mispredict), 32'(tbl[i].e_mis));
            chk($sformatf("tbl%0d_redirect", i), redirect_pc, tbl[i].e_red);
            tick();
        end
        chk("tbl_stat_br", 32'(stat_branches), 32'd10);
        chk("tbl_stat_mis", 32'(stat_mispredicts), 32'd8);

        // Ten more mispredicting branches push both counters into saturation.
        for (int i = 0; i < 10; i++) begin
            fetch_pc = 32'h100;
            drive(1, 32'h100 + 32'(4 * i), 1, 0, 1, 32'h80, 0, 32'h0);
            #3;
            chk("mis_run_mispredict", 32'(mispredict), 32'd1);
            tick();
        end
        chk("sat_stat_br", 32'(stat_branches), 32'(SMAX));
        chk("sat_stat_mis", 32'(stat_mispredicts), 32'(SMAX));

        // Asynchronous reset mid-cycle, held across a training edge.
        fetch_pc = 32'h104;
        drive(1, 32'h104, 0, 1, 1, 32'h900, 0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_stat_br", 32'(stat_branches), 32'd0);
        chk("async_rst_stat_mis", 32'(stat_mispredicts), 32'd0);
        chk("async_rst_pred_taken", 32'(pred_taken), 32'd0);
        tick();
        #2 rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        foreach (tbl[i]) begin
            if (i < 4) begin
                fetch_pc = 32'h100 + 32'(4 * i);
                #1;
                chk("post_rst_pred_taken", 32'(pred_taken), 32'd0);
                chk("post_rst_pred_target", pred_target, 32'h104 + 32'(4 * i));
            end
        end
        chk("post_rst_stat_br", 32'(stat_branches), 32'd0);
        tick();

        m_reset();
        for (int n = 0; n < 1500; n++) begin
            pc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
            tgt = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            k   = $urandom_range(0, 9);
            br  = (k <= 4) || (k == 9);
            jp  = (k == 5) || (k == 6) || (k == 9);
            tk  = jp ? 1'b1 : 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 7) != 0);
            p   = m_pred(pc);
            ppt = ($urandom_range(0, 3) != 0) ? p[32] : 1'($urandom_range(0, 1));
            ptgt = ($urandom_range(0, 3) != 0) ? p[31:0] : 32'h1000 + (32'($urandom_range(0, 15)) << 2);
            fetch_pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
            drive(v, pc, br, jp, tk, tgt, ppt, ptgt);
            #3;
            p = m_pred(fetch_pc);
            r = m_res(v, pc, br, jp, tk, tgt, ppt, ptgt);
            chk("rnd_pred_taken", 32'(pred_taken), 32'(p[32]));
            chk("rnd_pred_target", pred_target, p[31:0]);
            chk("rnd_mispredict", 32'(mispredict), 32'(r[32]));
            chk("rnd_redirect", redirect_pc, r[31:0]);
            chk("rnd_stat_br", 32'(stat_branches), 32'(m_nbr));
            chk("rnd_stat_mis", 32'(stat_mispredicts), 32'(m_nmis));
            tick();
            if (v) m_train(pc, br, jp, tk, tgt, ppt, r[32]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
